furv_dmem: RTL and testbench

Data-memory responder for the furv core's load/store port: the target end of the `mem_en`/`mem_read`/`addr`/`data_out` → `data_in`/`read_ack` handshake the core drives. The core launches requests on the falling edge; this block samples and responds on the rising edge, so a request issued at one falling edge can be consumed at the next. It holds a word-addressed synchronous RAM, inserts a configurable read latency, commits each store exactly once, and flags handshake violations for verification.

---
 rtl/furv_dmem.sv | 243 ++++++++++++++++++++++++
 tb/tb_furv_dmem.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/furv_dmem.sv
// ----------------------------------------------------------------------------
// furv_dmem -- data-memory responder for the furv core load/store port.
//
// The core launches a request on the falling edge; this block samples it on
// the next rising edge (P0). Loads return data after READ_LATENCY rising
// edges and hold read_ack until the core drops mem_en. Stores are committed
// exactly once at P0, and the block then waits for mem_en to fall.
// Handshake violations latch protocol_error until reset.
//
// Parameters:
//   DEPTH_LOG2    log2 of the RAM depth in 32-bit words
//   READ_LATENCY  rising edges from request sample to read_ack (1..15)
//   MMIO_ADDR     byte address of the console port (used with the macro)
//
// Build option:
//   FURV_DMEM_MMIO_EN  when defined, stores to MMIO_ADDR emit a one-cycle
//                      console strobe instead of writing the RAM, and loads
//                      from MMIO_ADDR return zero. When undefined, MMIO_ADDR
//                      is ordinary memory and mmio_valid/mmio_data stay 0.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   mem_en           request valid from the core
//   mem_read         1 = load, 0 = store (qualified by mem_en)
//   addr             byte address; word index = addr[DEPTH_LOG2+1:2]
//   data_out         store data from the core
//   data_in          load data to the core
//   read_ack         load data valid
//   protocol_error   sticky handshake-violation flag
//   mmio_valid       one-cycle console strobe
//   mmio_data        console byte
// ----------------------------------------------------------------------------
module furv_dmem #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] MMIO_ADDR    = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        read_ack,
    output logic        protocol_error,
    output logic        mmio_valid,
    output logic [7:0]  mmio_data
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // Initial RWAIT count: RWAIT is left on the edge where cnt reaches 0,
    // so READ_LATENCY-2 extra edges are spent counting down.
    localparam logic [3:0] CNT_INIT =
        4'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

`ifdef FURV_DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        ACK,
        WHOLD
    } state_t;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    idx_t        la_q;
    logic        la_mmio_q;

    logic [31:0] mem [DEPTH];

    idx_t        word;
    idx_t        rd_idx;
    logic        rd_zero;
    logic        mmio_hit;

    logic        la_load;
    logic        wr_en;
    logic        rd_capture;
    logic        ack_clr;
    logic        err_set;
    logic        mmio_fire;

    // Low address bits and bits above the RAM index are ignored, so upper
    // addresses alias into the RAM.
    assign word     = addr[DEPTH_LOG2+1:2];
    assign mmio_hit = MMIO_ON && (addr == MMIO_ADDR);

    // In IDLE the read uses the live address (latency 1); later it uses the
    // index latched when the load was accepted.
    assign rd_idx  = (state_q == IDLE) ? word : la_q;
    assign rd_zero = (state_q == IDLE) ? mmio_hit : la_mmio_q;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        la_load    = 1'b0;
        wr_en      = 1'b0;
        rd_capture = 1'b0;
        ack_clr    = 1'b0;
        err_set    = 1'b0;
        mmio_fire  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_en) begin
                    if (mem_read) begin
                        la_load = 1'b1;
                        if (READ_LATENCY == 1) begin
                            rd_capture = 1'b1;
                            state_d    = ACK;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = RWAIT;
                        end
                    end else begin
                        // Sole write point: a store held for several cycles
                        // is committed only here.
                        if (mmio_hit) begin
                            mmio_fire = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                        end
                        state_d = WHOLD;
                    end
                end
            end

            RWAIT: begin
                if (!mem_en) begin
                    // Core abandoned the load: abort without an ack.
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (!mem_read || (word != la_q)) begin
                        err_set = 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        rd_capture = 1'b1;
                        state_d    = ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            ACK: begin
                if (mem_en) begin
                    if (!mem_read || (word != la_q)) begin
                        err_set = 1'b1;
                    end
                end else begin
                    ack_clr = 1'b1;
                    state_d = IDLE;
                end
            end

            WHOLD: begin
                if (!mem_en) begin
                    state_d = IDLE;
                end else if (mem_read) begin
                    err_set = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            la_q           <= '0;
            la_mmio_q      <= 1'b0;
            data_in        <= 32'd0;
            read_ack       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (la_load) begin
                la_q      <= word;
                la_mmio_q <= mmio_hit;
            end
            if (rd_capture) begin
                data_in  <= rd_zero ? 32'd0 : mem[rd_idx];
                read_ack <= 1'b1;
            end else if (ack_clr) begin
                // data_in deliberately keeps the last loaded word.
                read_ack <= 1'b0;
            end
            if (err_set) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Console strobe (constant zero when the MMIO option is off)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_valid <= 1'b0;
            mmio_data  <= 8'd0;
        end else begin
            mmio_valid <= mmio_fire;
            if (mmio_fire) begin
                mmio_data <= data_out[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; contents survive rst_n, and leaving it
    // out of the reset network lets synthesis map it onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word] <= data_out;
        end
    end

endmodule

// File: tb/tb_furv_dmem.sv
// ----------------------------------------------------------------------------
// tb_furv_dmem -- self-checking bench for furv_dmem.
//
// Two instances share one stimulus: dut1 (READ_LATENCY=1) and dut4
// (READ_LATENCY=4). Each test observes the instance it targets. Inputs are
// driven on the falling edge, mirroring the core; outputs are sampled on the
// falling edge, half a cycle away from the sampling rising edge.
// ----------------------------------------------------------------------------
module tb_furv_dmem;

    localparam logic [31:0] MMIO_A = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en;
    logic        mem_read;
    logic [31:0] addr;
    logic [31:0] data_out;

    logic [31:0] d1_data, d4_data;
    logic        d1_ack, d4_ack;
    logic        d1_err, d4_err;
    logic        d1_mv, d4_mv;
    logic [7:0]  d1_md, d4_md;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    furv_dmem #(.DEPTH_LOG2(10), .READ_LATENCY(1), .MMIO_ADDR(MMIO_A)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en         (mem_en),
        .mem_read       (mem_read),
        .addr           (addr),
        .data_out       (data_out),
        .data_in        (d1_data),
        .read_ack       (d1_ack),
        .protocol_error (d1_err),
        .mmio_valid     (d1_mv),
        .mmio_data      (d1_md)
    );

    furv_dmem #(.DEPTH_LOG2(10), .READ_LATENCY(4), .MMIO_ADDR(MMIO_A)) dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_en         (mem_en),
        .mem_read       (mem_read),
        .addr           (addr),
        .data_out       (data_out),
        .data_in        (d4_data),
        .read_ack       (d4_ack),
        .protocol_error (d4_err),
        .mmio_valid     (d4_mv),
        .mmio_data      (d4_md)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic cur_ack(input bit sel);
        return sel ? d4_ack : d1_ack;
    endfunction

    function automatic logic [31:0] cur_data(input bit sel);
        return sel ? d4_data : d1_data;
    endfunction

    // Store: request at a falling edge, sampled at P0, dropped at the next
    // falling edge, then one idle rising edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b0;
        addr     = a;
        data_out = d;
        @(negedge clk);
        mem_en = 1'b0;
        @(negedge clk);
    endtask

    // Load on the selected instance; expected data goes through the
    // scoreboard queue and is popped when read_ack is seen.
    task automatic do_load(input bit sel, input logic [31:0] a,
                           input logic [31:0] exp, input string tag);
        int  lat_seen;
        bit  seen;
        logic [31:0] want;
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b1;
        addr     = a;
        exp_q.push_back(exp);
        seen     = 1'b0;
        lat_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!seen && cur_ack(sel)) begin
                seen     = 1'b1;
                lat_seen = k;
            end
            if (seen) break;
        end
        want = exp_q.pop_front();
        check({tag, " latency"}, 32'(lat_seen), sel ? 32'd4 : 32'd1);
        if (seen) begin
            check({tag, " data"}, cur_data(sel), want);
        end
        mem_en = 1'b0;
        @(negedge clk);
        check({tag, " ack drop"}, 32'(cur_ack(sel)), 32'd0);
        check({tag, " data kept"}, cur_data(sel), want);
    endtask

    typedef struct {
        string       name;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic [31:0] ld_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"st/ld 0x40",    32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0040, 32'hDEAD_BEEF};
        vecs[1] = '{"alias 0x1000",  32'h0000_1000, 32'h0000_00A5, 32'h0000_0000, 32'h0000_00A5};
        vecs[2] = '{"top word",      32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0FFC, 32'hCAFE_F00D};
        vecs[3] = '{"low bits",      32'h0000_0043, 32'h1122_3344, 32'h0000_0040, 32'h1122_3344};
        vecs[4] = '{"high alias",    32'h8000_0044, 32'h0000_0055, 32'h0000_0044, 32'h0000_0055};

        rst_n    = 1'b0;
        mem_en   = 1'b0;
        mem_read = 1'b0;
        addr     = 32'd0;
        data_out = 32'd0;

        // Reset state
        @(negedge clk);
        check("reset data_in",        d1_data, 32'd0);
        check("reset read_ack",       32'(d1_ack), 32'd0);
        check("reset protocol_error", 32'(d1_err), 32'd0);
        check("reset mmio_valid",     32'(d1_mv), 32'd0);
        check("reset mmio_data",      32'(d1_md), 32'd0);
        check("reset read_ack lat4",  32'(d4_ack), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: store then load on the latency-1 instance
        for (int i = 0; i < 5; i++) begin
            do_store(vecs[i].st_addr, vecs[i].st_data);
            do_load(1'b0, vecs[i].ld_addr, vecs[i].exp, vecs[i].name);
        end
        check("lat1 no violation", 32'(d1_err), 32'd0);

        // Latency 4
        do_store(32'h0, 32'h1234_5678);
        do_load(1'b1, 32'h0, 32'h1234_5678, "lat4");

        // Store held for three cycles with changing data
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b0;
        addr     = 32'h8;
        data_out = 32'd1;
        @(negedge clk);
        data_out = 32'd2;
        @(negedge clk);
        data_out = 32'd3;
        @(negedge clk);
        mem_en = 1'b0;
        @(negedge clk);
        check("held store no error", 32'(d1_err), 32'd0);
        do_load(1'b0, 32'h8, 32'd1, "held store");

        // Violation: address change during RWAIT
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("lat4 err cleared", 32'(d4_err), 32'd0);
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b1;
        addr     = 32'h40;
        @(negedge clk);
        check("rwait no error yet", 32'(d4_err), 32'd0);
        addr = 32'h80;
        @(negedge clk);
        check("rwait addr change", 32'(d4_err), 32'd1);
        mem_en = 1'b0;
        repeat (4) @(negedge clk);
        check("error sticky", 32'(d4_err), 32'd1);
        check("aborted load no ack", 32'(d4_ack), 32'd0);
        rst_n = 1'b0;
        #1;
        check("error cleared by reset", 32'(d4_err), 32'd0);

        // Reset during ACK, then restart of the still-held request
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b1;
        addr     = 32'h40;
        @(negedge clk);
        check("ack before reset", 32'(d1_ack), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ack drops on reset", 32'(d1_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart ack", 32'(d1_ack), 32'd1);
        check("restart data", d1_data, 32'h1122_3344);
        mem_en = 1'b0;
        @(negedge clk);
        check("restart ack drop", 32'(d1_ack), 32'd0);

        // Console port
        do_store(32'h0000_0FF0, 32'h0000_0077);
        @(negedge clk);
        mem_en   = 1'b1;
        mem_read = 1'b0;
        addr     = MMIO_A;
        data_out = 32'h0000_0041;
        @(negedge clk);
`ifdef FURV_DMEM_MMIO_EN
        check("mmio strobe",      32'(d1_mv), 32'd1);
        check("mmio byte",        32'(d1_md), 32'h41);
`else
        check("mmio strobe off",  32'(d1_mv), 32'd0);
        check("mmio byte off",    32'(d1_md), 32'd0);
`endif
        mem_en = 1'b0;
        @(negedge clk);
        check("mmio strobe one cycle", 32'(d1_mv), 32'd0);
`ifdef FURV_DMEM_MMIO_EN
        do_load(1'b0, 32'h0000_0FF0, 32'h0000_0077, "mmio ram untouched");
        do_load(1'b0, MMIO_A,        32'h0000_0000, "mmio load zero");
`else
        do_load(1'b0, 32'h0000_0FF0, 32'h0000_0041, "mmio addr is ram");
        do_load(1'b0, MMIO_A,        32'h0000_0041, "mmio addr load");
`endif
        check("final no violation", 32'(d1_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
